pipe_stage_skid: RTL
====================

// Module: pipe_stage_skid
// PURPOSE
//  Parametrised pipeline stage register with valid/ready backpressure and a 2-entry skid buffer.
//  Generalises the fixed-field inter-stage registers: one instance carries a DATA_W payload plus a
//  CTRL_W control field between any two CPU stages (ID/EX, EX/MEM, ...), with flush, halt and
//  registered ready so stalls propagate without combinational ready chains. Control field zero = bubble.
// PARAMETERS
//  DATA_W   128  payload width (PCs, operands, immediates, sprite fields)
//  CTRL_W   16   control width (write enables, flag-update bits, opcodes); all-zero means no-op
//  STAT_W   16   width of statistics counters (only used with PIPE_STATS_EN)
// PORTS
//  clk         in   1       clock, all state updates on rising edge
//  rst_n       in   1       asynchronous active-low reset
//  flush       in   1       synchronous squash of all held entries
//  hlt         in   1       processor halt: freezes stage, blocks both handshakes
//  in_valid    in   1       upstream entry valid
//  in_ready    out  1       stage can accept this cycle
//  in_data     in   DATA_W  upstream payload
//  in_ctrl     in   CTRL_W  upstream control
//  out_valid   out  1       entry presented downstream
//  out_ready   in   1       downstream accepts this cycle
//  out_data    out  DATA_W  payload of head entry, zero when empty
//  out_ctrl    out  CTRL_W  control of head entry, zero when empty
//  stall_cnt   out  STAT_W  (PIPE_STATS_EN only) cycles with out_valid & !out_ready
//  bubble_cnt  out  STAT_W  (PIPE_STATS_EN only) non-halted cycles with head empty
// BEHAVIOUR
//  - Storage: head register (drives outputs) + skid register. State EMPTY / ONE / FULL.
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - in_ready = (state != FULL) & !hlt & !flush. out_valid = head_valid & !hlt.
//  - Transitions (flush=0, hlt=0):
//    EMPTY: push -> ONE, head<=in.
//    ONE:   push&pop -> ONE, head<=in; push&!pop -> FULL, skid<=in; pop&!push -> EMPTY.
//    FULL:  pop -> ONE, head<=skid; else hold.
//  - Latency 1 cycle accept-to-out_valid; throughput 1 entry/cycle; FIFO order preserved.
//  - out_data/out_ctrl forced to 0 whenever head empty (bubble reads as no-op).
//  - flush: priority over everything; next state EMPTY, head and skid cleared to 0; any in_valid
//    presented that cycle is dropped (in_ready=0); pop does not occur.
//  - hlt (flush=0): all registers hold; no push, no pop; resumes exactly where frozen.
//  - Reset (async, any time incl. mid-transfer): state EMPTY, head/skid=0; outputs
//    out_valid=0, out_data=0, out_ctrl=0, in_ready=!hlt; counters=0.
//  - in_data/in_ctrl are don't-care when in_valid=0 and are never captured then.
// CONFIGURATION
//  - Macro PIPE_STATS_EN: when defined, stall_cnt and bubble_cnt ports exist; each is a
//    STAT_W saturating counter (sticks at all-ones), cleared only by rst_n, unaffected by flush.
//    stall_cnt +1 on out_valid & !out_ready; bubble_cnt +1 on !head_valid & !hlt.
//  - Undefined: ports and counter logic absent; datapath behaviour identical.
// STRUCTURE
//  - Package pipe_pkg: typedef enum {EMPTY, ONE, FULL} skid_state_t (2 bits);
//    default width constants PIPE_DATA_W, PIPE_CTRL_W, PIPE_STAT_W.
//  - Sub-module pipe_sat_ctr (STAT_W, inc, clk, rst_n -> cnt), instantiated twice under
//    PIPE_STATS_EN. Storage and FSM stay in this module.
// TESTING
//  - Reset: rst_n low mid-stream with FULL -> out_valid=0, out_data=0, out_ctrl=0, in_ready=1.
//  - Streaming: in_valid=1, out_ready=1, data 1..8 -> out 1..8 one cycle later, no gaps, never FULL.
//  - Backpressure: out_ready=0 after push A,B -> state FULL, in_ready=0, out=A held;
//    out_ready=1 -> A then B out, in_ready=1 again the cycle after A pops.
//  - Flush in FULL with in_valid=1 data C -> next cycle EMPTY, out_ctrl=0, C never appears.
//  - Halt: hlt=1 for 5 cycles in ONE with out_ready=1 -> out_valid=0, in_ready=0, head unchanged;
//    hlt=0 -> same entry delivered once.
//  - PIPE_STATS_EN, STAT_W=4: hold out_ready=0 for 20 valid cycles -> stall_cnt=15 (saturated).

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module : pipe_pkg
// Brief  : Shared types and default widths for the skid-buffered pipeline stage.
// Rev    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  localparam int PIPE_DATA_W = 128;
  localparam int PIPE_CTRL_W = 16;
  localparam int PIPE_STAT_W = 16;

endpackage
`default_nettype wire

// File: rtl/pipe_sat_ctr.sv
`default_nettype none
// ============================================================================
// Module : pipe_sat_ctr
// Brief  : Saturating event counter; sticks at all-ones, cleared only by rst_n.
// Rev    : 1.0 - initial release
// ============================================================================
module pipe_sat_ctr
  import pipe_pkg::*;
#(
  parameter int STAT_W = PIPE_STAT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  output logic [STAT_W-1:0] cnt
);

  localparam logic [STAT_W-1:0] C_MAX = {STAT_W{1'b1}};
  localparam logic [STAT_W-1:0] C_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

  logic [STAT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != C_MAX)) begin
      r_cnt <= r_cnt + C_ONE;
    end
  end

  assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module : pipe_stage_skid
// Brief  : Pipeline stage register with valid/ready handshake, 2-entry skid
//          buffer, flush and halt. Optional statistics counters are built
//          when PIPE_STATS_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W
`ifdef PIPE_STATS_EN
  ,
  parameter int STAT_W = PIPE_STAT_W
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              hlt,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] bubble_cnt
`endif
);

  skid_state_t       r_state,     w_state_nxt;
  logic [DATA_W-1:0] r_head_data, w_head_data_nxt;
  logic [CTRL_W-1:0] r_head_ctrl, w_head_ctrl_nxt;
  logic [DATA_W-1:0] r_skid_data, w_skid_data_nxt;
  logic [CTRL_W-1:0] r_skid_ctrl, w_skid_ctrl_nxt;
  logic              w_head_valid;
  logic              w_push;
  logic              w_pop;

  // Ready depends only on registered state plus hlt/flush, so no ready chain forms.
  assign w_head_valid = (r_state != EMPTY);
  assign in_ready     = (r_state != FULL) && !hlt && !flush;
  assign out_valid    = w_head_valid && !hlt;
  assign w_push       = in_valid && in_ready;
  assign w_pop        = out_valid && out_ready && !flush;

  always_comb begin
    w_state_nxt     = r_state;
    w_head_data_nxt = r_head_data;
    w_head_ctrl_nxt = r_head_ctrl;
    w_skid_data_nxt = r_skid_data;
    w_skid_ctrl_nxt = r_skid_ctrl;
    if (flush) begin
      w_state_nxt     = EMPTY;
      w_head_data_nxt = '0;
      w_head_ctrl_nxt = '0;
      w_skid_data_nxt = '0;
      w_skid_ctrl_nxt = '0;
    end else begin
      // hlt already forces push and pop low, so every branch below holds.
      case (r_state)
        EMPTY: begin
          if (w_push) begin
            w_state_nxt     = ONE;
            w_head_data_nxt = in_data;
            w_head_ctrl_nxt = in_ctrl;
          end
        end
        ONE: begin
          if (w_push && w_pop) begin
            w_head_data_nxt = in_data;
            w_head_ctrl_nxt = in_ctrl;
          end else if (w_push) begin
            w_state_nxt     = FULL;
            w_skid_data_nxt = in_data;
            w_skid_ctrl_nxt = in_ctrl;
          end else if (w_pop) begin
            w_state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (w_pop) begin
            w_state_nxt     = ONE;
            w_head_data_nxt = r_skid_data;
            w_head_ctrl_nxt = r_skid_ctrl;
          end
        end
        default: begin
          w_state_nxt = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_head_data <= '0;
      r_head_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_head_data <= w_head_data_nxt;
      r_head_ctrl <= w_head_ctrl_nxt;
      r_skid_data <= w_skid_data_nxt;
      r_skid_ctrl <= w_skid_ctrl_nxt;
    end
  end

  // An empty head reads as a no-op downstream.
  assign out_data = w_head_valid ? r_head_data : '0;
  assign out_ctrl = w_head_valid ? r_head_ctrl : '0;

`ifdef PIPE_STATS_EN
  pipe_sat_ctr #(
    .STAT_W (STAT_W)
  ) u_stall_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid && !out_ready),
    .cnt   (stall_cnt)
  );

  pipe_sat_ctr #(
    .STAT_W (STAT_W)
  ) u_bubble_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!w_head_valid && !hlt),
    .cnt   (bubble_cnt)
  );
`endif

endmodule
`default_nettype wire
